stw_mac_pe: RTL and testbench

Parametrised weight/input-stationary MAC processing element for the systolic array, with a built-in multi-vector self-test window (STW) and fault-bypass repair. Each PE holds up to NUM_VEC test vectors and runs them back-to-back on its own multiplier/adder while the array datapath is frozen. It counts miscompares and raises a sticky fault flag. When repair is enabled, a faulty PE forwards partial sums unchanged, so the array tolerates it as a zero-contribution PE.

---
 rtl/stw_mac_pe.sv | 158 +++++++++++++++
 tb/tb_stw_mac_pe.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stw_mac_pe.sv
// MAC processing element for the systolic array with a built-in self-test window:
// stored test vectors run on the PE's own multiplier/adder while the datapath is frozen.
module stw_mac_pe #(
  parameter int WORD_SIZE   = 16,
  parameter int ACC_WIDTH   = 32,
  parameter int NUM_VEC     = 4,
  parameter int FAIL_THRESH = 1,
  localparam int VW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1,
  localparam int CW = $clog2(NUM_VEC + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fsm_op2_select_in,
  input  logic                 fsm_out_select_in,
  input  logic                 stat_bit_in,
  input  logic [WORD_SIZE-1:0] left_in,
  input  logic [ACC_WIDTH-1:0] top_in,
  output logic [WORD_SIZE-1:0] right_out,
  output logic [ACC_WIDTH-1:0] bottom_out,
  input  logic                 vec_wr_en,
  input  logic [VW-1:0]        vec_wr_addr,
  input  logic [WORD_SIZE-1:0] vec_op1,
  input  logic [WORD_SIZE-1:0] vec_op2,
  input  logic [ACC_WIDTH-1:0] vec_add,
  input  logic [ACC_WIDTH-1:0] vec_expected,
  input  logic                 stw_start,
  input  logic                 clear_fault,
  input  logic                 bypass_en,
  output logic                 stw_busy,
  output logic                 stw_done,
  output logic                 stw_pass,
  output logic [CW-1:0]        stw_fail_count,
  output logic                 faulty
);

  localparam int PW = 2 * WORD_SIZE + ACC_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_EVAL} state_t;

  state_t state, state_nxt;

  logic [WORD_SIZE-1:0] left_in_p0;
  logic [ACC_WIDTH-1:0] top_in_p0;
  logic [WORD_SIZE-1:0] stat_p0;
  logic [ACC_WIDTH-1:0] acc_p1;

  logic [WORD_SIZE-1:0] vop1_mem [NUM_VEC];
  logic [WORD_SIZE-1:0] vop2_mem [NUM_VEC];
  logic [ACC_WIDTH-1:0] vadd_mem [NUM_VEC];
  logic [ACC_WIDTH-1:0] vexp_mem [NUM_VEC];

  logic [VW-1:0]        idx;
  logic                 run;
  logic                 bypass;
  logic [WORD_SIZE-1:0] op1;
  logic [WORD_SIZE-1:0] op2;
  logic [ACC_WIDTH-1:0] addend;
  logic [ACC_WIDTH-1:0] sum;

  // Unsigned product, zero-extended then truncated to the accumulator width.
  function automatic logic [ACC_WIDTH-1:0] mac_sum(input logic [WORD_SIZE-1:0] a,
                                                   input logic [WORD_SIZE-1:0] b,
                                                   input logic [ACC_WIDTH-1:0] c);
    logic [PW-1:0] prod;
    prod = PW'(a) * PW'(b);
    return prod[ACC_WIDTH-1:0] + c;
  endfunction

  assign stw_busy = (state != S_IDLE);
  assign run      = (state == S_RUN);
  assign bypass   = faulty & bypass_en;

  // The self-test borrows the same multiplier/adder that the datapath uses.
  assign op1    = run ? vop1_mem[idx] : left_in_p0;
  assign op2    = run ? vop2_mem[idx] : (stat_bit_in ? stat_p0 : top_in_p0[WORD_SIZE-1:0]);
  assign addend = run ? vadd_mem[idx] : (stat_bit_in ? top_in_p0 : acc_p1);
  assign sum    = mac_sum(op1, op2, addend);

  assign right_out  = left_in_p0;
  assign bottom_out = (bypass || !fsm_out_select_in) ? top_in_p0 : acc_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (stw_start) state_nxt = S_RUN;
      S_RUN:   if (idx == VW'(NUM_VEC - 1)) state_nxt = S_EVAL;
      S_EVAL:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p0 operand registers and p1 accumulator; all frozen during a test.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_in_p0 <= '0;
      top_in_p0  <= '0;
      stat_p0    <= '0;
      acc_p1     <= '0;
    end else if (!stw_busy) begin
      left_in_p0 <= left_in;
      top_in_p0  <= top_in;
      if (fsm_op2_select_in) stat_p0 <= top_in[WORD_SIZE-1:0];
      if (!bypass) acc_p1 <= sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VEC; i++) begin
        vop1_mem[i] <= '0;
        vop2_mem[i] <= '0;
        vadd_mem[i] <= '0;
        vexp_mem[i] <= '0;
      end
    end else if (vec_wr_en && !stw_busy && (int'(vec_wr_addr) < NUM_VEC)) begin
      vop1_mem[vec_wr_addr] <= vec_op1;
      vop2_mem[vec_wr_addr] <= vec_op2;
      vadd_mem[vec_wr_addr] <= vec_add;
      vexp_mem[vec_wr_addr] <= vec_expected;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx            <= '0;
      stw_fail_count <= '0;
      stw_done       <= 1'b0;
      stw_pass       <= 1'b1;
      faulty         <= 1'b0;
    end else begin
      stw_done <= (state == S_EVAL);
      case (state)
        S_IDLE: begin
          if (clear_fault) faulty <= 1'b0;
          if (stw_start) begin
            idx            <= '0;
            stw_fail_count <= '0;
          end
        end
        S_RUN: begin
          if (sum != vexp_mem[idx]) stw_fail_count <= stw_fail_count + CW'(1);
          if (idx != VW'(NUM_VEC - 1)) idx <= idx + VW'(1);
        end
        S_EVAL: begin
          stw_pass <= (stw_fail_count == '0);
          if (stw_fail_count >= CW'(FAIL_THRESH)) faulty <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stw_mac_pe.sv
// Randomized scoreboard bench for stw_mac_pe: self-test outcomes are queued at start
// and checked on each done pulse; the datapath is compared against a behavioural model.
module tb_stw_mac_pe;
  localparam int W  = 16;
  localparam int A  = 32;
  localparam int NV = 4;
  localparam int TH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fsm_op2_select_in = 1'b0, fsm_out_select_in = 1'b0, stat_bit_in = 1'b0;
  logic [W-1:0]  left_in = '0;
  logic [A-1:0]  top_in = '0;
  logic [W-1:0]  right_out;
  logic [A-1:0]  bottom_out;
  logic          vec_wr_en = 1'b0;
  logic [1:0]    vec_wr_addr = '0;
  logic [W-1:0]  vec_op1 = '0, vec_op2 = '0;
  logic [A-1:0]  vec_add = '0, vec_expected = '0;
  logic          stw_start = 1'b0, clear_fault = 1'b0, bypass_en = 1'b0;
  logic          stw_busy, stw_done, stw_pass, faulty;
  logic [2:0]    stw_fail_count;

  stw_mac_pe #(.WORD_SIZE(W), .ACC_WIDTH(A), .NUM_VEC(NV), .FAIL_THRESH(TH)) dut (
    .clk(clk), .rst_n(rst_n),
    .fsm_op2_select_in(fsm_op2_select_in), .fsm_out_select_in(fsm_out_select_in),
    .stat_bit_in(stat_bit_in), .left_in(left_in), .top_in(top_in),
    .right_out(right_out), .bottom_out(bottom_out),
    .vec_wr_en(vec_wr_en), .vec_wr_addr(vec_wr_addr), .vec_op1(vec_op1), .vec_op2(vec_op2),
    .vec_add(vec_add), .vec_expected(vec_expected),
    .stw_start(stw_start), .clear_fault(clear_fault), .bypass_en(bypass_en),
    .stw_busy(stw_busy), .stw_done(stw_done), .stw_pass(stw_pass),
    .stw_fail_count(stw_fail_count), .faulty(faulty)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit pass;
    int cnt;
    bit flt;
  } stw_exp_t;
  stw_exp_t sb_q[$];

  // Behavioural model state
  logic [W-1:0] m_left, m_stat;
  logic [A-1:0] m_top, m_acc;
  bit           m_faulty, m_busy, m_eval;
  bit           m_faulty_eval;
  logic [W-1:0] t_op1[NV], t_op2[NV];
  logic [A-1:0] t_add[NV], t_exp[NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [A-1:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [A-1:0] c);
    longint unsigned r;
    r = longint'(a) * longint'(b) + longint'(c);
    return A'(r % (64'd1 << A));
  endfunction

  function automatic logic [A-1:0] exp_bottom();
    if ((m_faulty && bypass_en) || !fsm_out_select_in) return m_top;
    return m_acc;
  endfunction

  task automatic model_reset();
    m_left = '0; m_stat = '0; m_top = '0; m_acc = '0;
    m_faulty = 0; m_busy = 0; m_eval = 0;
    for (int i = 0; i < NV; i++) begin
      t_op1[i] = '0; t_op2[i] = '0; t_add[i] = '0; t_exp[i] = '0;
    end
  endtask

  // One clock: model follows the inputs present at the edge, then outputs are compared.
  task automatic tick();
    logic [A-1:0] s;
    s = stat_bit_in ? ref_sum(m_left, m_stat, m_top) : ref_sum(m_left, m_top[W-1:0], m_acc);
    @(posedge clk);
    if (!m_busy) begin
      if (!(m_faulty && bypass_en)) m_acc = s;
      if (fsm_op2_select_in) m_stat = top_in[W-1:0];
      m_left = left_in;
      m_top  = top_in;
      if (vec_wr_en) begin
        t_op1[vec_wr_addr] = vec_op1; t_op2[vec_wr_addr] = vec_op2;
        t_add[vec_wr_addr] = vec_add; t_exp[vec_wr_addr] = vec_expected;
      end
      if (clear_fault) m_faulty = 0;
    end
    if (m_eval) m_faulty = m_faulty_eval;
    #1;
    chk("right_out", right_out, m_left);
    chk("bottom_out", bottom_out, exp_bottom());
  endtask

  task automatic write_vec(input int a, input logic [W-1:0] o1, input logic [W-1:0] o2,
                           input logic [A-1:0] ad, input logic [A-1:0] ex);
    vec_wr_en = 1'b1; vec_wr_addr = 2'(a);
    vec_op1 = o1; vec_op2 = o2; vec_add = ad; vec_expected = ex;
    tick();
    vec_wr_en = 1'b0;
  endtask

  task automatic mac_cycle(input logic [W-1:0] l, input logic [A-1:0] t, input bit st,
                           input bit osel, input bit o2sel);
    left_in = l; top_in = t; stat_bit_in = st; fsm_out_select_in = osel;
    fsm_op2_select_in = o2sel;
    tick();
    fsm_op2_select_in = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("rst right_out", right_out, 0);
    chk("rst bottom_out", bottom_out, 0);
    chk("rst busy", stw_busy, 0);
    chk("rst done", stw_done, 0);
    chk("rst pass", stw_pass, 1);
    chk("rst fail_count", stw_fail_count, 0);
    chk("rst faulty", faulty, 0);
    #1;
    rst_n = 1'b1;
  endtask

  // abort_at > 0 applies reset after that many RUN cycles.
  task automatic run_stw(input bit clr, input bit poke, input int abort_at);
    stw_exp_t e;
    int cnt = 0;
    for (int i = 0; i < NV; i++)
      if (ref_sum(t_op1[i], t_op2[i], t_add[i]) != t_exp[i]) cnt++;
    e.pass = (cnt == 0);
    e.cnt  = cnt;
    e.flt  = (clr ? 1'b0 : m_faulty) | (cnt >= TH);
    sb_q.push_back(e);
    stw_start = 1'b1; clear_fault = clr;
    tick();
    stw_start = 1'b0; clear_fault = 1'b0;
    m_busy = 1;
    chk("busy at start", stw_busy, 1);
    chk("fail_count cleared", stw_fail_count, 0);
    chk("faulty after start", faulty, m_faulty);
    for (int k = 1; k <= NV; k++) begin
      left_in = W'($urandom); top_in = $urandom;
      fsm_op2_select_in = 1'b1;
      if (poke && k == 2) begin
        stw_start = 1'b1; vec_wr_en = 1'b1; vec_wr_addr = 2'd1;
        vec_op1 = 16'h1; vec_op2 = 16'h1; vec_add = '0; vec_expected = 32'hDEAD;
      end
      tick();
      stw_start = 1'b0; vec_wr_en = 1'b0; fsm_op2_select_in = 1'b0;
      if (k == abort_at) begin
        void'(sb_q.pop_back());
        do_reset();
        return;
      end
      chk("busy during run", stw_busy, 1);
    end
    m_faulty_eval = e.flt;
    m_eval = 1;
    tick();
    m_eval = 0; m_busy = 0;
    chk("busy after eval", stw_busy, 0);
    chk("done pulse", stw_done, 1);
    tick();
    chk("done single cycle", stw_done, 0);
  endtask

  // Scoreboard monitor: each done pulse consumes one queued expectation.
  always @(negedge clk) begin
    if (rst_n && stw_done) begin
      if (sb_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL unexpected done: no test outstanding at %0t", $time);
      end else begin
        stw_exp_t e;
        e = sb_q.pop_front();
        checks += 3;
        if (stw_pass !== e.pass) begin
          errors++; $display("FAIL stw_pass: got %0b, expected %0b", stw_pass, e.pass);
        end
        if (int'(stw_fail_count) != e.cnt) begin
          errors++; $display("FAIL stw_fail_count: got %0d, expected %0d", stw_fail_count, e.cnt);
        end
        if (faulty !== e.flt) begin
          errors++; $display("FAIL faulty at done: got %0b, expected %0b", faulty, e.flt);
        end
      end
    end
  end

  initial begin
    model_reset();
    #7;
    do_reset();

    // Stationary MAC: 5*3+7
    mac_cycle(16'd0, 32'd3, 1'b1, 1'b1, 1'b1);
    mac_cycle(16'd5, 32'd7, 1'b1, 1'b1, 1'b0);
    mac_cycle(16'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    chk("stationary mac 22", bottom_out, 32'd22);

    for (int i = 0; i < 30; i++)
      mac_cycle(W'($urandom), $urandom, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));

    // Passing self-test; accumulator visible on bottom_out must hold
    fsm_out_select_in = 1'b1;
    write_vec(0, 16'd2, 16'd3, 32'd4, 32'd10);
    write_vec(1, 16'hFFFF, 16'hFFFF, 32'd1, 32'hFFFE0002);
    write_vec(2, 16'd100, 16'd200, 32'd7, 32'd20007);
    write_vec(3, 16'h8000, 16'h0004, 32'hFFFF_0000, 32'h0001_0000);
    run_stw(1'b0, 1'b0, 0);

    // Two miscompares reach the threshold
    write_vec(0, 16'd2, 16'd3, 32'd4, 32'd11);
    write_vec(2, 16'd100, 16'd200, 32'd7, 32'd0);
    run_stw(1'b0, 1'b0, 0);
    chk("faulty set", faulty, 1);
    bypass_en = 1'b1;
    mac_cycle(16'h55, 32'h1234, 1'b1, 1'b1, 1'b0);
    chk("bypass bottom_out", bottom_out, 32'h1234);
    for (int i = 0; i < 8; i++)
      mac_cycle(W'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'b0);

    // Clear with start on a faulty PE; one miscompare stays below threshold
    write_vec(2, 16'd100, 16'd200, 32'd7, 32'd20007);
    run_stw(1'b1, 1'b0, 0);
    chk("below threshold faulty", faulty, 0);
    chk("below threshold pass", stw_pass, 0);
    for (int i = 0; i < 4; i++)
      mac_cycle(W'($urandom), $urandom, 1'($urandom), 1'b1, 1'b0);

    // start and vector write while busy are ignored
    write_vec(0, 16'd2, 16'd3, 32'd4, 32'd10);
    run_stw(1'b0, 1'b1, 0);
    run_stw(1'b0, 1'b0, 0);
    chk("storage unchanged pass", stw_pass, 1);

    // Reset mid-run, then a full run on cleared storage
    run_stw(1'b0, 1'b0, 2);
    run_stw(1'b0, 1'b0, 0);
    chk("post-reset pass", stw_pass, 1);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NV; i++) begin
        logic [W-1:0] a, b;
        logic [A-1:0] c, x;
        a = W'($urandom); b = W'($urandom); c = $urandom;
        x = ref_sum(a, b, c);
        if ($urandom_range(0, 2) == 0) x = x ^ (32'd1 << $urandom_range(0, 31));
        write_vec(i, a, b, c, x);
      end
      bypass_en = 1'($urandom);
      run_stw(1'($urandom), 1'b0, 0);
      for (int i = 0; i < 5; i++)
        mac_cycle(W'($urandom), $urandom, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
    end

    repeat (3) tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL missing done: %0d tests outstanding, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
